load_store_unit: RTL and testbench

- Multi-cycle load/store unit between the core's memory-access stage and the word-addressed data memory.
- Accepts byte, halfword and word requests; drives the memory's mem_read/mem_write/endereco/write_data port.
- Extracts and sign/zero-extends loads; performs sub-word stores as read-modify-write.
- Flags misaligned and out-of-range accesses.

---
 rtl/load_store_unit_if.sv | 33 +++
 rtl/load_store_unit.sv | 181 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Core-request, response and data-memory signals of the load/store unit.
// slave: the unit's view. master: the core/memory side's view.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] endereco;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_read, mem_write, endereco, write_data,
    input  read_data
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_read, mem_write, endereco, write_data,
    output read_data
  );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit between the core's memory stage and a
// word-addressed data memory. Byte/half/word loads with sign/zero extension,
// sub-word stores via read-modify-write, misalignment and range faults.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (defined = misaligned half/word
// accesses fault; undefined = low address bits ignored, access aligned down).
module load_store_unit #(
  parameter int unsigned MEM_IDX_W   = 5,
  parameter bit          RANGE_CHECK = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  load_store_unit_if.slave bus
);

  localparam int unsigned DATA_W  = 32;
  localparam logic [1:0]  SZ_BYTE = 2'b00;
  localparam logic [1:0]  SZ_HALF = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RD   = 2'b01,
    S_WR   = 2'b10,
    S_RESP = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic                write_q, write_d;
  logic [1:0]          size_q, size_d;
  logic                unsigned_q, unsigned_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   old_q, old_d;
  logic                fault_q, fault_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                misalign_c;
  logic                range_c;

  // Shift the addressed lane(s) down and extend to a full word.
  function automatic logic [DATA_W-1:0] load_extract(
    input logic [DATA_W-1:0] w,
    input logic [1:0]        sz,
    input logic [1:0]        a,
    input logic              uns
  );
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    b = 8'(w >> {a, 3'b000});
    h = 16'(w >> {a[1], 4'b0000});
    case (sz)
      SZ_BYTE: r = uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace the addressed lane(s) of the old word with the right-aligned store data.
  function automatic logic [DATA_W-1:0] store_merge(
    input logic [DATA_W-1:0] old,
    input logic [DATA_W-1:0] nw,
    input logic [1:0]        sz,
    input logic [1:0]        a
  );
    logic [DATA_W-1:0] m;
    logic [DATA_W-1:0] d;
    case (sz)
      SZ_BYTE: begin
        m = 32'h0000_00FF << {a, 3'b000};
        d = {24'b0, nw[7:0]} << {a, 3'b000};
      end
      SZ_HALF: begin
        m = 32'h0000_FFFF << {a[1], 4'b0000};
        d = {16'b0, nw[15:0]} << {a[1], 4'b0000};
      end
      default: begin
        m = '1;
        d = nw;
      end
    endcase
    return (old & ~m) | (d & m);
  endfunction

  // Fault classification of the incoming request.
  always_comb begin
    misalign_c = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_c = ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                 (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
`endif
    range_c = RANGE_CHECK && ((bus.req_addr[31:2] >> MEM_IDX_W) != 30'd0);
  end

  // State register and captured request fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      write_q    <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      old_q      <= '0;
      fault_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      old_q      <= old_d;
      fault_q    <= fault_d;
      rdata_q    <= rdata_d;
    end
  end

  // Next-state and capture logic.
  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    old_d      = old_q;
    fault_d    = fault_q;
    rdata_d    = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          write_d    = bus.req_write;
          size_d     = bus.req_size;
          unsigned_d = bus.req_unsigned;
          addr_d     = bus.req_addr;
          wdata_d    = bus.req_wdata;
          fault_d    = misalign_c || range_c;
          rdata_d    = '0;
          if (misalign_c || range_c) begin
            state_d = S_RESP;
          end else if (bus.req_write && bus.req_size[1]) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (write_q) begin
          old_d   = bus.read_data;
          state_d = S_WR;
        end else begin
          rdata_d = load_extract(bus.read_data, size_q, addr_q[1:0], unsigned_q);
          state_d = S_RESP;
        end
      end
      S_WR: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state only.
  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_error = (state_q == S_RESP) && fault_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.mem_read   = (state_q == S_RD);
  assign bus.mem_write  = (state_q == S_WR);
  assign bus.endereco   = {2'b00, addr_q[31:2]};
  assign bus.write_data = store_merge(old_q, wdata_q, size_q, addr_q[1:0]);

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed steps followed by random requests,
// checked against a word-array reference model of the memory and the
// access rules.
module tb_load_store_unit;

  localparam int unsigned MEM_WORDS = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic mem_clear;
  int   checks   = 0;
  int   failures = 0;

  logic [31:0] mem     [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];
  logic [31:0] last_rdata;
  logic        last_err;

  always #5 clk = ~clk;

  load_store_unit_if bus();

  load_store_unit #(.MEM_IDX_W(5), .RANGE_CHECK(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Data memory: combinational read, write on posedge.
  assign bus.read_data = mem[bus.endereco[4:0]];

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= (i == 0) ? 32'h0000_0FFF : 32'h0;
    end else if (bus.mem_write) begin
      mem[bus.endereco[4:0]] <= bus.write_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request and check timing, strobes and response against the model.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] idx, ea, old, nw, exp_rdata, v, mask;
    logic        flt;
    int          exp_lat, exp_rd, exp_wr, sh;
    int          lat, rd_c, wr_c, rd_n, wr_n;
    logic [31:0] got_rdata;
    logic        got_err;

    idx = addr >> 2;
    flt = (idx >= MEM_WORDS);
`ifdef LSU_MISALIGN_TRAP_EN
    if (sz == 2'd1 && addr[0]) flt = 1'b1;
    if (sz >= 2'd2 && addr[1:0] != 2'd0) flt = 1'b1;
`endif
    ea = addr;
    if (sz == 2'd1) ea = addr & ~32'd1;
    if (sz >= 2'd2) ea = addr & ~32'd3;

    exp_rdata = 32'd0;
    nw = 32'd0;
    exp_rd = 0;
    exp_wr = 0;
    if (flt) begin
      exp_lat = 1;
    end else begin
      old = ref_mem[idx];
      if (sz == 2'd0) begin
        sh = (ea % 4) * 8;
        mask = 32'hFF << sh;
        v = (old >> sh) & 32'hFF;
        if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
        nw = (old & ~mask) | ((wd & 32'hFF) << sh);
      end else if (sz == 2'd1) begin
        sh = ((ea >> 1) % 2) * 16;
        mask = 32'hFFFF << sh;
        v = (old >> sh) & 32'hFFFF;
        if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
        nw = (old & ~mask) | ((wd & 32'hFFFF) << sh);
      end else begin
        v = old;
        nw = wd;
      end
      if (!wr) begin
        exp_lat = 2; exp_rd = 1; exp_rdata = v;
      end else if (sz >= 2'd2) begin
        exp_lat = 2; exp_wr = 1;
      end else begin
        exp_lat = 3; exp_rd = 1; exp_wr = 2;
      end
    end

    @(negedge clk);
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    bus.req_valid    = 1'b1;
    chk("req_ready_before", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;

    lat = 0; rd_c = 0; wr_c = 0; rd_n = 0; wr_n = 0;
    got_rdata = 32'hX; got_err = 1'bX;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      if (bus.mem_read) begin
        rd_c = c; rd_n++;
        chk("rd_endereco", bus.endereco, idx);
      end
      if (bus.mem_write) begin
        wr_c = c; wr_n++;
        chk("wr_endereco", bus.endereco, idx);
        chk("write_data", bus.write_data, nw);
      end
      if (bus.resp_valid) begin
        lat = c;
        got_rdata = bus.resp_rdata;
        got_err = bus.resp_error;
        break;
      end
    end
    chk("resp_latency", 32'(lat), 32'(exp_lat));
    chk("resp_rdata", got_rdata, exp_rdata);
    chk("resp_error", 32'(got_err), 32'(flt));
    chk("mem_read_cycle", 32'(rd_c), 32'(exp_rd));
    chk("mem_write_cycle", 32'(wr_c), 32'(exp_wr));
    chk("strobe_count", 32'(rd_n + wr_n), 32'((exp_rd != 0 ? 1 : 0) + (exp_wr != 0 ? 1 : 0)));
    last_rdata = got_rdata;
    last_err = got_err;
    if (wr && !flt) ref_mem[idx] = nw;

    @(posedge clk);
    #1;
    chk("resp_pulse_single", 32'(bus.resp_valid), 32'd0);
    chk("req_ready_after", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n            = 1'b0;
    mem_clear        = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'd0;
    bus.req_wdata    = 32'd0;
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = (i == 0) ? 32'h0000_0FFF : 32'h0;

    // Reset state
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_error", 32'(bus.resp_error), 32'd0);
    chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
    chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_endereco", bus.endereco, 32'd0);
    chk("rst_write_data", bus.write_data, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mem_clear = 1'b0;

    // Loads from word 0 = 0x00000FFF
    do_req(1'b0, 2'd0, 1'b1, 32'h1, 32'h0);
    chk("tp_lbu_1", last_rdata, 32'h0000_000F);
    do_req(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    chk("tp_lb_0", last_rdata, 32'hFFFF_FFFF);
    do_req(1'b0, 2'd1, 1'b0, 32'h0, 32'h0);
    chk("tp_lh_0", last_rdata, 32'h0000_0FFF);

    // Half store (read-modify-write) then word readback
    do_req(1'b1, 2'd1, 1'b0, 32'h6, 32'h1234_ABCD);
    do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
    chk("tp_lw_4", last_rdata, 32'hABCD_0000);

    // Word store then top byte readback
    do_req(1'b1, 2'd2, 1'b0, 32'h8, 32'hDEAD_BEEF);
    do_req(1'b0, 2'd0, 1'b1, 32'hB, 32'h0);
    chk("tp_lbu_b", last_rdata, 32'h0000_00DE);

    // Misaligned word load
    do_req(1'b0, 2'd2, 1'b0, 32'h2, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("tp_misalign_err", 32'(last_err), 32'd1);
    chk("tp_misalign_rdata", last_rdata, 32'd0);
`else
    chk("tp_misalign_err", 32'(last_err), 32'd0);
    chk("tp_misalign_rdata", last_rdata, 32'h0000_0FFF);
`endif

    // Out-of-range load and store
    do_req(1'b0, 2'd2, 1'b0, 32'h80, 32'h0);
    chk("tp_range_err", 32'(last_err), 32'd1);
    do_req(1'b1, 2'd0, 1'b0, 32'h0000_1000, 32'h77);

    // Reset during WR of a byte store
    @(negedge clk);
    bus.req_write = 1'b1; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h55; bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_wr_reached", 32'(bus.mem_write), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_wr_mem_write", 32'(bus.mem_write), 32'd0);
    chk("rst_wr_mem_read", 32'(bus.mem_read), 32'd0);
    chk("rst_wr_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_wr_req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("rst_wr_no_resp", 32'(bus.resp_valid), 32'd0);
    end
    chk("rst_wr_word0", mem[0], 32'h0000_0FFF);
    chk("rst_wr_word0_model", mem[0], ref_mem[0]);

    // Random traffic
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = 32'($urandom_range(0, 4 * MEM_WORDS - 1));
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, $urandom);
    end

    // Final memory image
    for (int i = 0; i < MEM_WORDS; i++) chk($sformatf("mem_word_%0d", i), mem[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
